// File: rtl/eoc_pkg.sv
// eoc_pkg
// Shared constants for the end-of-column readout receiver: word widths,
// the bit layout of the tagged output word and frame trailer, and the
// frame state encoding.
//   Output word : {is_trailer, addr_col, payload[DATA_W-1:0]}
//   Trailer     : payload = {1'b0, word_cnt[CNT_W-1:0], TimeStamp[TS_W-1:0]}
package eoc_pkg;

    localparam int DATA_W       = 26;
    localparam int CNT_W        = 16;
    localparam int TS_W         = 9;
    localparam int OUT_W        = DATA_W + 2;

    // Positions inside the tagged output word
    localparam int TRL_FLAG_BIT = OUT_W - 1;
    localparam int ADDR_BIT     = OUT_W - 2;

    // Positions of the trailer fields inside the payload
    localparam int TRL_TS_LSB   = 0;
    localparam int TRL_CNT_LSB  = TS_W;
    localparam int TRL_PAD_BIT  = TS_W + CNT_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQ     = 2'd1,
        DRAIN   = 2'd2,
        TRAILER = 2'd3
    } eoc_state_e;

    // Builds the tagged trailer word from its fields
    function automatic logic [OUT_W-1:0] make_trailer(
        input logic             addr,
        input logic [CNT_W-1:0] cnt,
        input logic [TS_W-1:0]  ts
    );
        return {1'b1, addr, 1'b0, cnt, ts};
    endfunction

endpackage

// File: rtl/eoc_readout_rx_if.sv
// eoc_readout_rx_if
// Groups the two word streams of the receiver:
//   chain side : col_data / col_valid in, shake_hands_next back to the chain
//   output side: out_data / out_valid to the serializer, out_ready back
// modport master : the environment (chain + serializer)
// modport slave  : the receiver itself
interface eoc_readout_rx_if;
    import eoc_pkg::*;

    logic [DATA_W-1:0] col_data;
    logic              col_valid;
    logic              shake_hands_next;
    logic [OUT_W-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output col_data, col_valid, out_ready,
        input  shake_hands_next, out_data, out_valid
    );

    modport slave (
        input  col_data, col_valid, out_ready,
        output shake_hands_next, out_data, out_valid
    );

endinterface

// File: rtl/eoc_sync_fifo.sv
// eoc_sync_fifo
// Single-clock first-word-fall-through FIFO. The head word is visible on
// rd_data whenever rd_valid is high; rd_en pops it.
// Ports:
//   clk, rst_n       clock, asynchronous active-low clear of pointers/count
//   wr_en, wr_data   push (ignored when full)
//   rd_en            pop (ignored when empty)
//   rd_data, rd_valid head word, forced to 0 when empty
//   count            number of stored words, 0..DEPTH
module eoc_sync_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign do_wr    = wr_en && (count != FULL_COUNT);
    assign do_rd    = rd_en && (count != '0);
    assign rd_valid = (count != '0);
    // Empty FIFO presents zero rather than stale storage
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    // Storage needs no reset: nothing is visible until count says so
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/eoc_readout_rx.sv
// eoc_readout_rx
// End-of-column receiver for the super-pixel readout daisy chain. Accepts
// hit words from the last super pixel, tags them with the column address,
// buffers them in a FWFT FIFO and, after each shutter close once the chain
// has gone quiet, appends a frame trailer with word count and TimeStamp.
// Ports:
//   clk_40MHz   sole clock
//   rst_n       asynchronous active-low reset
//   shutter     acquisition window (synchronous)
//   TimeStamp   coarse time, captured into the trailer
//   addr_col    column address tagged into every word
//   bus         slave side of eoc_readout_rx_if (chain + output streams)
//   frame_busy  high while a frame is open, draining or awaiting its trailer
module eoc_readout_rx
    import eoc_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int DRAIN_CYC = 16
) (
    input  logic            clk_40MHz,
    input  logic            rst_n,
    input  logic            shutter,
    input  logic [TS_W-1:0] TimeStamp,
    input  logic            addr_col,
    eoc_readout_rx_if.slave bus,
    output logic            frame_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = $clog2(DRAIN_CYC + 1);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(DRAIN_CYC - 1);

    eoc_state_e       state;
    eoc_state_e       state_next;
    logic             shutter_d;
    logic             run_q;
    logic [IW-1:0]    idle_cnt;
    logic [CNT_W-1:0] word_cnt;
    logic [AW:0]      fifo_count;
    logic             fifo_full;
    logic             shake;
    logic             accept;
    logic             trailer_wr;
    logic             drain_done;
    logic [OUT_W-1:0] wr_data;

    assign fifo_full  = (fifo_count == FULL_COUNT);
    // run_q keeps the chain blocked while reset is asserted
    assign shake      = run_q && !fifo_full && (state != TRAILER);
    assign accept     = bus.col_valid && shake;
    assign trailer_wr = (state == TRAILER) && !fifo_full;
    // The cycle whose idle increment would reach DRAIN_CYC
    assign drain_done = (state == DRAIN) && !bus.col_valid && (idle_cnt == IDLE_LAST);
    assign wr_data    = trailer_wr ? make_trailer(addr_col, word_cnt, TimeStamp)
                                   : {1'b0, addr_col, bus.col_data};

    assign bus.shake_hands_next = shake;
    assign frame_busy           = (state != IDLE);

    eoc_sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk_40MHz),
        .rst_n    (rst_n),
        .wr_en    (accept || trailer_wr),
        .wr_data  (wr_data),
        .rd_en    (bus.out_ready),
        .rd_data  (bus.out_data),
        .rd_valid (bus.out_valid),
        .count    (fifo_count)
    );

    // State register plus the delayed shutter used for edge detection
    always_ff @(posedge clk_40MHz or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            shutter_d <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state     <= state_next;
            shutter_d <= shutter;
            run_q     <= 1'b1;
        end
    end

    // Frame sequencing: open on shutter, drain after its fall, then trailer
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (shutter) state_next = ACQ;
            ACQ:     if (shutter_d && !shutter) state_next = DRAIN;
            DRAIN:   if (drain_done) state_next = TRAILER;
            TRAILER: if (trailer_wr) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Quiet-chain counter: held at zero during acquisition so DRAIN starts
    // fresh, and restarted by any late hit offered while draining
    always_ff @(posedge clk_40MHz or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (state == ACQ) begin
            idle_cnt <= '0;
        end else if (state == DRAIN) begin
            idle_cnt <= bus.col_valid ? '0 : idle_cnt + 1'b1;
        end
    end

    // Saturating frame word counter, cleared as its value leaves in a trailer
    always_ff @(posedge clk_40MHz or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
        end else if (trailer_wr) begin
            word_cnt <= '0;
        end else if (accept && (word_cnt != '1)) begin
            word_cnt <= word_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_eoc_readout_rx.sv
// tb_eoc_readout_rx
// Directed bench for eoc_readout_rx. Expected output words are pushed to a
// scoreboard queue when the bench sees a word accepted (or knows a trailer
// is due); a monitor pops and compares on every output transfer.
`timescale 1ns/1ps
module tb_eoc_readout_rx;
    import eoc_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            shutter;
    logic [TS_W-1:0] TimeStamp;
    logic            addr_col;
    logic            frame_busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_trailer_cyc = -1;

    logic [OUT_W-1:0] sb[$];

    eoc_readout_rx_if bus ();

    eoc_readout_rx #(
        .DEPTH     (8),
        .DRAIN_CYC (16)
    ) dut (
        .clk_40MHz  (clk),
        .rst_n      (rst_n),
        .shutter    (shutter),
        .TimeStamp  (TimeStamp),
        .addr_col   (addr_col),
        .bus        (bus),
        .frame_busy (frame_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Scoreboard monitor: every output transfer must match the queue head
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            checkOutput("unexpected_output", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                logic [OUT_W-1:0] exp_w;
                exp_w = sb.pop_front();
                checkOutput("out_word", 32'(bus.out_data), 32'(exp_w));
                if (bus.out_data[TRL_FLAG_BIT]) last_trailer_cyc = cyc;
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        sb.delete();
        tick(3);
        bus.col_valid = 1'b0;
        rst_n = 1'b1;
        tick(1);
    endtask

    // Offers consecutive words to the chain port, honouring the handshake
    task automatic applyStimulus(input int n, input logic [DATA_W-1:0] base,
                                 input int budget, output int accepted);
        accepted = 0;
        for (int c = 0; c < budget && accepted < n; c++) begin
            bus.col_valid = 1'b1;
            bus.col_data  = base + DATA_W'(accepted);
            @(negedge clk);
            if (bus.shake_hands_next) begin
                sb.push_back({1'b0, addr_col, bus.col_data});
                accepted++;
            end
            @(posedge clk);
            #1;
        end
        bus.col_valid = 1'b0;
    endtask

    task automatic waitEmpty(input string tag, input int budget);
        for (int c = 0; c < budget && sb.size() != 0; c++) tick(1);
        tick(2);
        checkOutput(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        int fall_cyc;

        rst_n         = 1'b0;
        shutter       = 1'b0;
        TimeStamp     = 9'h0A5;
        addr_col      = 1'b1;
        bus.col_data  = '0;
        bus.col_valid = 1'b1;
        bus.out_ready = 1'b1;

        // 1: reset with the chain offering a word
        tick(3);
        @(negedge clk);
        checkOutput("rst_shake", 32'(bus.shake_hands_next), 32'd0);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(bus.out_data), 32'd0);
        checkOutput("rst_frame_busy", 32'(frame_busy), 32'd0);
        @(posedge clk); #1;
        bus.col_valid = 1'b0;
        rst_n = 1'b1;
        tick(1);
        @(negedge clk);
        checkOutput("post_rst_shake", 32'(bus.shake_hands_next), 32'd1);
        checkOutput("post_rst_empty", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;

        // 2: single word, first-word fall-through latency and tagging
        applyStimulus(1, 26'h2A55A5, 4, acc);
        checkOutput("single_accepted", 32'(acc), 32'd1);
        @(negedge clk);
        checkOutput("single_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("single_word", 32'(bus.out_data), 32'h042A55A5);
        checkOutput("single_trl_flag", 32'(bus.out_data[TRL_FLAG_BIT]), 32'd0);
        checkOutput("single_addr", 32'(bus.out_data[ADDR_BIT]), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("single_popped", 32'(bus.out_valid), 32'd0);
        @(posedge clk); #1;

        // 3: backpressure fills the FIFO, then everything drains in order
        addr_col      = 1'b0;
        bus.out_ready = 1'b0;
        applyStimulus(10, 26'h0001000, 12, acc);
        checkOutput("bp_accepted", 32'(acc), 32'd8);
        @(negedge clk);
        checkOutput("bp_shake_low", 32'(bus.shake_hands_next), 32'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        applyStimulus(2, 26'h0001008, 10, acc);
        checkOutput("bp_rest_accepted", 32'(acc), 32'd2);
        waitEmpty("bp_drain", 40);

        // 4: basic frame with three words and a trailer
        addr_col = 1'b1;
        resetDut();
        shutter = 1'b1;
        applyStimulus(3, 26'h0002000, 6, acc);
        tick(1);
        shutter  = 1'b0;
        fall_cyc = cyc;
        sb.push_back(make_trailer(1'b1, 16'd3, 9'h0A5));
        tick(2);
        checkOutput("frame_busy_drain", 32'(frame_busy), 32'd1);
        waitEmpty("frame_trailer", 60);
        checkOutput("frame_trailer_late", 32'(last_trailer_cyc - fall_cyc >= 16), 32'd1);
        checkOutput("frame_idle", 32'(frame_busy), 32'd0);

        // 5: late hit in DRAIN restarts the quiet count and joins the frame
        shutter = 1'b1;
        applyStimulus(2, 26'h0003000, 6, acc);
        shutter = 1'b0;
        tick(10);
        applyStimulus(1, 26'h0003100, 4, acc);
        checkOutput("late_accepted", 32'(acc), 32'd1);
        sb.push_back(make_trailer(1'b1, 16'd3, 9'h0A5));
        tick(12);
        checkOutput("late_still_busy", 32'(frame_busy), 32'd1);
        checkOutput("late_trailer_pending", 32'(sb.size()), 32'd1);
        waitEmpty("late_trailer", 40);

        // 6: trailer blocked behind a full FIFO
        bus.out_ready = 1'b0;
        shutter = 1'b1;
        applyStimulus(8, 26'h0004000, 10, acc);
        checkOutput("blk_accepted", 32'(acc), 32'd8);
        shutter = 1'b0;
        sb.push_back(make_trailer(1'b1, 16'd8, 9'h0A5));
        tick(30);
        checkOutput("blk_busy", 32'(frame_busy), 32'd1);
        applyStimulus(1, 26'h0004100, 3, acc);
        checkOutput("blk_chain_held", 32'(acc), 32'd0);
        bus.out_ready = 1'b1;
        waitEmpty("blk_trailer", 40);
        checkOutput("blk_idle", 32'(frame_busy), 32'd0);

        // Reset in the middle of DRAIN drops the pending trailer
        shutter = 1'b1;
        applyStimulus(1, 26'h0005000, 4, acc);
        shutter = 1'b0;
        tick(5);
        resetDut();
        tick(40);
        checkOutput("mid_rst_no_words", 32'(sb.size()), 32'd0);
        checkOutput("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("mid_rst_idle", 32'(frame_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
